// File: rtl/sobel_ctrl_pkg.sv
// Shared types and widths for the Sobel parameter controller.
// Imported by sobel_ctrl and key_hold_repeat.
package sobel_ctrl_pkg;

    localparam int THR_W = 11;

    typedef enum logic [1:0] {
        BYPASS    = 2'd0,
        GRAY      = 2'd1,
        SOBEL     = 2'd2,
        SOBEL_INV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/key_hold_repeat.sv
// Press-and-hold auto-repeat for one key.
// Steps on the press edge, then repeats on frame boundaries.
module key_hold_repeat
    import sobel_ctrl_pkg::*;
#(
    parameter int REPEAT_DLY = 30,
    parameter int REPEAT_PER = 4
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_key_d,
    input  logic i_fb,
    input  logic i_block,
    output logic o_step
);

    localparam int CW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
    localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] C_TOP = CW'(REPEAT_DLY + REPEAT_PER);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_inc;

    assign w_inc = r_cnt + 1'b1;

    // Counter folds back to DLY every PER frames, so it never wraps.
    always_comb begin
        w_cnt_nx = r_cnt;
        o_step   = 1'b0;
        if (i_block || !i_key) begin
            w_cnt_nx = '0;
        end else if (!i_key_d) begin
            w_cnt_nx = '0;
            o_step   = 1'b1;
        end else if (i_fb) begin
            if (w_inc == C_TOP) begin
                w_cnt_nx = C_DLY;
                o_step   = 1'b1;
            end else begin
                w_cnt_nx = w_inc;
                o_step   = (w_inc == C_DLY);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
        end
    end

endmodule

// File: rtl/sobel_ctrl.sv
// Frame-synchronous threshold/mode controller for the Sobel pipeline.
// Key edits stay pending and commit on the vsync rising edge.
module sobel_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int THR_INIT   = 100,
    parameter int THR_STEP   = 8,
    parameter int THR_MAX    = 2047,
    parameter int REPEAT_DLY = 30,
    parameter int REPEAT_PER = 4
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    input  logic             iVGA_vs,
    input  logic             iKey_up,
    input  logic             iKey_dn,
    input  logic             iKey_mode,
    output logic [THR_W-1:0] oKey_value,
    output logic [1:0]       oMode,
    output logic             oCfg_valid,
    output logic             oCommit,
    output logic [15:0]      oFrame_cnt
);

    logic r_vs_d1, r_vs_d2;
    logic r_up_d1, r_up_d2;
    logic r_dn_d1, r_dn_d2;
    logic r_md_d1, r_md_d2;

    logic             w_fb;
    logic             w_block;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_md_edge;
    logic             w_chg;
    logic             w_commit;
    logic [THR_W:0]   w_sum;
    logic [THR_W:0]   w_diff;
    logic [THR_W-1:0] w_thr_nx;
    mode_e            w_mode_nx;
    state_e           w_state_nx;

    state_e           r_state;
    logic [THR_W-1:0] r_pend_thr;
    mode_e            r_pend_mode;
    logic [THR_W-1:0] r_com_thr;
    mode_e            r_com_mode;
    logic             r_valid;
    logic             r_commit;
    logic [15:0]      r_fcnt;

    assign w_fb      = r_vs_d1 & ~r_vs_d2;
    assign w_md_edge = r_md_d1 & ~r_md_d2;
    assign w_block   = r_up_d1 & r_dn_d1;

    key_hold_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_up (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .i_key   (r_up_d1),
        .i_key_d (r_up_d2),
        .i_fb    (w_fb),
        .i_block (w_block),
        .o_step  (w_step_up)
    );

    key_hold_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_dn (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .i_key   (r_dn_d1),
        .i_key_d (r_dn_d2),
        .i_fb    (w_fb),
        .i_block (w_block),
        .o_step  (w_step_dn)
    );

    // One spare bit catches overflow above MAX and borrow below 0.
    assign w_sum  = {1'b0, r_pend_thr} + (THR_W+1)'(THR_STEP);
    assign w_diff = {1'b0, r_pend_thr} - (THR_W+1)'(THR_STEP);

    always_comb begin
        w_thr_nx = r_pend_thr;
        if (w_step_up) begin
            if (w_sum > (THR_W+1)'(THR_MAX)) begin
                w_thr_nx = THR_W'(THR_MAX);
            end else begin
                w_thr_nx = w_sum[THR_W-1:0];
            end
        end else if (w_step_dn) begin
            if (w_diff[THR_W]) begin
                w_thr_nx = '0;
            end else begin
                w_thr_nx = w_diff[THR_W-1:0];
            end
        end
    end

    assign w_mode_nx = w_md_edge ? mode_e'(r_pend_mode + 2'd1)
                                 : r_pend_mode;
    assign w_chg = (w_thr_nx != r_pend_thr) ||
                   (w_mode_nx != r_pend_mode);

    always_comb begin
        w_state_nx = r_state;
        w_commit   = 1'b0;
        unique case (r_state)
            SYNC: begin
                if (w_fb) begin
                    w_commit   = 1'b1;
                    w_state_nx = w_chg ? PEND : RUN;
                end
            end
            RUN: begin
                if (w_chg) begin
                    w_state_nx = PEND;
                end
            end
            PEND: begin
                if (w_fb) begin
                    w_commit   = 1'b1;
                    w_state_nx = w_chg ? PEND : RUN;
                end
            end
            default: w_state_nx = SYNC;
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1     <= 1'b0;
            r_vs_d2     <= 1'b0;
            r_up_d1     <= 1'b0;
            r_up_d2     <= 1'b0;
            r_dn_d1     <= 1'b0;
            r_dn_d2     <= 1'b0;
            r_md_d1     <= 1'b0;
            r_md_d2     <= 1'b0;
            r_state     <= SYNC;
            r_pend_thr  <= THR_W'(THR_INIT);
            r_pend_mode <= SOBEL;
            r_com_thr   <= THR_W'(THR_INIT);
            r_com_mode  <= SOBEL;
            r_valid     <= 1'b0;
            r_commit    <= 1'b0;
            r_fcnt      <= '0;
        end else begin
            r_vs_d1     <= iVGA_vs;
            r_vs_d2     <= r_vs_d1;
            r_up_d1     <= iKey_up;
            r_up_d2     <= r_up_d1;
            r_dn_d1     <= iKey_dn;
            r_dn_d2     <= r_dn_d1;
            r_md_d1     <= iKey_mode;
            r_md_d2     <= r_md_d1;
            r_state     <= w_state_nx;
            r_pend_thr  <= w_thr_nx;
            r_pend_mode <= w_mode_nx;
            r_commit    <= w_commit;
            // Commit takes pending as it stood before this cycle's key event.
            if (w_commit) begin
                r_com_thr  <= r_pend_thr;
                r_com_mode <= r_pend_mode;
                r_valid    <= 1'b1;
            end
            if (w_fb) begin
                r_fcnt <= r_fcnt + 16'd1;
            end
        end
    end

    assign oKey_value = r_com_thr;
    assign oMode      = r_com_mode;
    assign oCfg_valid = r_valid;
    assign oCommit    = r_commit;
    assign oFrame_cnt = r_fcnt;

endmodule

// File: tb/tb_sobel_ctrl.sv
// Bench for sobel_ctrl: frame-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_sobel_ctrl;

    localparam int INIT = 100;
    localparam int STEP = 8;
    localparam int TMAX = 2047;
    localparam int DLY  = 30;
    localparam int PER  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        up = 1'b0;
    logic        dn = 1'b0;
    logic        md = 1'b0;
    logic [10:0] key_value;
    logic [1:0]  mode;
    logic        cfg_valid;
    logic        commit;
    logic [15:0] fcnt;

    int n_err = 0;
    int n_chk = 0;
    int n_commit = 0;
    int saved;

    always #5 clk = ~clk;

    sobel_ctrl dut (
        .vga_clk    (clk),
        .rst_n      (rst_n),
        .iVGA_vs    (vs),
        .iKey_up    (up),
        .iKey_dn    (dn),
        .iKey_mode  (md),
        .oKey_value (key_value),
        .oMode      (mode),
        .oCfg_valid (cfg_valid),
        .oCommit    (commit),
        .oFrame_cnt (fcnt)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: whole-frame view of pending/committed settings.
    int m_thr, m_mode, c_thr, c_mode;
    int m_fcnt, hold_up, hold_dn;
    bit m_valid, m_commit, m_dirty;
    bit v1, v2, u1, u2, d1, d2, k1, k2;

    function automatic bit rep_hit(input int held);
        return held >= DLY && ((held - DLY) % PER) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        bit fb, su, sd, chg, cm;
        int nthr, nmode, nhu, nhd;
        if (!rst_n) begin
            m_thr <= INIT;    m_mode <= 2;
            c_thr <= INIT;    c_mode <= 2;
            m_fcnt <= 0;      m_valid <= 0;
            m_commit <= 0;    m_dirty <= 0;
            hold_up <= 0;     hold_dn <= 0;
            v1 <= 0; v2 <= 0; u1 <= 0; u2 <= 0;
            d1 <= 0; d2 <= 0; k1 <= 0; k2 <= 0;
        end else begin
            fb = v1 && !v2;
            su = 0; sd = 0;
            nhu = hold_up; nhd = hold_dn;
            if (u1 && d1) begin
                nhu = 0; nhd = 0;
            end else begin
                if (!u1) nhu = 0;
                else if (!u2) begin su = 1; nhu = 0; end
                else if (fb) begin
                    nhu = hold_up + 1; su = rep_hit(nhu);
                end
                if (!d1) nhd = 0;
                else if (!d2) begin sd = 1; nhd = 0; end
                else if (fb) begin
                    nhd = hold_dn + 1; sd = rep_hit(nhd);
                end
            end
            nthr = m_thr;
            if (su) nthr = (m_thr + STEP > TMAX) ? TMAX : m_thr + STEP;
            else if (sd) nthr = (m_thr < STEP) ? 0 : m_thr - STEP;
            nmode = (k1 && !k2) ? (m_mode + 1) % 4 : m_mode;
            chg = (nthr != m_thr) || (nmode != m_mode);
            cm = fb && (!m_valid || m_dirty);
            if (cm) begin
                c_thr <= m_thr; c_mode <= m_mode; m_valid <= 1;
            end
            if (!m_valid) m_dirty <= fb && chg;
            else if (cm) m_dirty <= chg;
            else m_dirty <= m_dirty || chg;
            m_commit <= cm;
            if (fb) m_fcnt <= (m_fcnt + 1) % 65536;
            m_thr <= nthr; m_mode <= nmode;
            hold_up <= nhu; hold_dn <= nhd;
            v1 <= vs; v2 <= v1; u1 <= up; u2 <= u1;
            d1 <= dn; d2 <= d1; k1 <= md; k2 <= k1;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_key_value", key_value, c_thr);
        chk("model_mode", mode, c_mode);
        chk("model_cfg_valid", cfg_valid, m_valid);
        chk("model_commit", commit, m_commit);
        chk("model_frame_cnt", fcnt, m_fcnt);
        if (commit) n_commit++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync();
        vs = 1'b1; tick(3);
        vs = 1'b0; tick(13);
    endtask

    task automatic tap_up();
        up = 1'b1; tick(3);
        up = 1'b0; tick(3);
    endtask

    task automatic tap_dn();
        dn = 1'b1; tick(3);
        dn = 1'b0; tick(3);
    endtask

    task automatic tap_md();
        md = 1'b1; tick(3);
        md = 1'b0; tick(3);
    endtask

    initial begin
        tick(3);
        chk("rst_key_value", key_value, 100);
        chk("rst_mode", mode, 2);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_commit", commit, 0);
        chk("rst_frame_cnt", fcnt, 0);
        rst_n = 1'b1;
        tick(4);
        chk("pre_fb_valid", cfg_valid, 0);

        vs = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("fb1_commit", commit, 1);
        chk("fb1_valid", cfg_valid, 1);
        chk("fb1_frame_cnt", fcnt, 1);
        @(negedge clk); tick(2);
        vs = 1'b0; tick(13);
        vsync();
        chk("fb2_frame_cnt", fcnt, 2);

        saved = n_commit;
        tap_up(); tap_up(); tap_up();
        chk("taps_hold_value", key_value, 100);
        vsync();
        chk("taps_value", key_value, 124);
        chk("taps_one_commit", n_commit - saved, 1);

        tap_dn(); tap_dn(); tap_dn();
        vsync();
        chk("back_to_100", key_value, 100);

        dn = 1'b1; tick(2);
        vsync();
        chk("dn_press", key_value, 92);
        for (int i = 2; i <= 30; i++) vsync();
        chk("dn_before_rep", key_value, 92);
        vsync();
        chk("dn_first_rep", key_value, 84);
        for (int i = 32; i <= 78; i++) vsync();
        chk("dn_clamp", key_value, 0);
        saved = n_commit;
        vsync(); vsync();
        dn = 1'b0; tick(4);
        vsync();
        chk("dn_stuck_no_commit", n_commit - saved, 0);
        chk("dn_stuck_value", key_value, 0);

        for (int i = 0; i < 255; i++) tap_up();
        vsync();
        chk("set_2040", key_value, 2040);
        tap_up();
        vsync();
        chk("up_sat", key_value, 2047);
        saved = n_commit;
        tap_up();
        vsync();
        chk("sat_no_commit", n_commit - saved, 0);
        chk("sat_value", key_value, 2047);

        saved = n_commit;
        up = 1'b1; dn = 1'b1; tick(2);
        vsync(); vsync(); vsync();
        up = 1'b0; dn = 1'b0; tick(4);
        vsync();
        chk("conflict_no_commit", n_commit - saved, 0);
        chk("conflict_value", key_value, 2047);

        tap_dn();
        vs = 1'b1; md = 1'b1; tick(3);
        vs = 1'b0; md = 1'b0; tick(13);
        chk("md_fb_old_mode", mode, 2);
        chk("md_fb_thr", key_value, 2039);
        vsync();
        chk("md_next_fb", mode, 3);
        tap_md(); vsync();
        chk("md_wrap0", mode, 0);
        tap_md(); vsync();
        chk("md_1", mode, 1);
        tap_md(); vsync();
        chk("md_2", mode, 2);

        rst_n = 1'b0; tick(2);
        rst_n = 1'b1; tick(3);
        vsync();
        tap_up(); tap_up(); tap_up(); tap_up(); tap_up();
        chk("pend_hold", key_value, 100);
        rst_n = 1'b0; #1;
        chk("rst2_key_value", key_value, 100);
        chk("rst2_mode", mode, 2);
        chk("rst2_valid", cfg_valid, 0);
        chk("rst2_frame_cnt", fcnt, 0);
        tick(2);
        rst_n = 1'b1; tick(3);
        chk("rst2_sync_valid", cfg_valid, 0);
        vsync();
        chk("rst2_discard", key_value, 100);
        chk("rst2_valid_after", cfg_valid, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
